// File: rtl/acc_bank.sv
// Bank of DEPTH independent signed accumulators with per-channel sticky overflow
// flags and a registered, single-cycle-latency read port.
module acc_bank #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int SAT   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    input  logic [2:0]               op,
    input  logic [$clog2(DEPTH)-1:0] sel,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic [DEPTH-1:0]         ovf,
    input  logic                     ovf_clr
);

    localparam logic [2:0] OP_LOAD     = 3'b001;
    localparam logic [2:0] OP_ADD      = 3'b010;
    localparam logic [2:0] OP_SUB      = 3'b011;
    localparam logic [2:0] OP_CLR      = 3'b100;
    localparam logic [2:0] OP_READ     = 3'b101;
    localparam logic [2:0] OP_READ_CLR = 3'b110;

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] acc [DEPTH];
    logic [WIDTH-1:0] acc_cur;
    logic [WIDTH:0]   sum;
    logic             ovf_hit;
    logic [WIDTH-1:0] arith_res;

    // Handshake: op_valid is a strobe with no backpressure; a command is
    // consumed at every rising edge where op_valid is high and rst is low.
    always_comb begin
        acc_cur   = acc[sel];
        sum       = '0;
        ovf_hit   = 1'b0;
        arith_res = '0;
        if (op == OP_SUB) begin
            sum = {acc_cur[WIDTH-1], acc_cur} - {din[WIDTH-1], din};
        end else begin
            sum = {acc_cur[WIDTH-1], acc_cur} + {din[WIDTH-1], din};
        end
        // The two top bits of the widened result disagree exactly on signed overflow.
        ovf_hit = sum[WIDTH] ^ sum[WIDTH-1];
        if (ovf_hit && (SAT != 0)) begin
            arith_res = sum[WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            arith_res = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '{default: '0};
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= '0;
        end else begin
            dout_valid <= 1'b0;
            if (ovf_clr) begin
                ovf <= '0;
            end
            // Later bit set overrides the bulk clear above, so a new overflow wins.
            if (op_valid) begin
                case (op)
                    OP_LOAD: acc[sel] <= din;
                    OP_ADD, OP_SUB: begin
                        acc[sel] <= arith_res;
                        if (ovf_hit) begin
                            ovf[sel] <= 1'b1;
                        end
                    end
                    OP_CLR: acc[sel] <= '0;
                    OP_READ: begin
                        dout       <= acc_cur;
                        dout_valid <= 1'b1;
                    end
                    OP_READ_CLR: begin
                        dout       <= acc_cur;
                        dout_valid <= 1'b1;
                        acc[sel]   <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acc_bank.sv
// Bench for acc_bank: a wrap instance and a saturating instance share stimulus;
// table vectors plus hand sequences, read data checked through an expected queue.
module tb_acc_bank;

    localparam int W = 18;
    localparam int D = 4;

    localparam logic [2:0] NOP = 3'd0, LD = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] CLR = 3'd4, RD = 3'd5, RDC = 3'd6, RSV = 3'd7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_valid = 1'b0;
    logic [2:0]   op = '0;
    logic [1:0]   sel = '0;
    logic [W-1:0] din = '0;
    logic         ovf_clr = 1'b0;

    logic [W-1:0] dout0, dout1;
    logic         dv0, dv1;
    logic [D-1:0] ovf0, ovf1;

    acc_bank #(.WIDTH(W), .DEPTH(D), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .sel(sel), .din(din),
        .dout(dout0), .dout_valid(dv0), .ovf(ovf0), .ovf_clr(ovf_clr)
    );

    acc_bank #(.WIDTH(W), .DEPTH(D), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .sel(sel), .din(din),
        .dout(dout1), .dout_valid(dv1), .ovf(ovf1), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [2:0]   op;
        logic [1:0]   sel;
        logic [W-1:0] din;
        logic         oc;
        logic [W-1:0] exp_d;
        logic [D-1:0] exp_ovf;
    } vec_t;

    vec_t         tbl[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_dout = '0;
    int           nvec = 0;
    int           nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [2:0] o, input logic [1:0] s,
                       input logic [W-1:0] d, input logic oc,
                       input logic [W-1:0] ed, input logic [D-1:0] eo);
        vec_t t;
        t.v = v; t.op = o; t.sel = s; t.din = d; t.oc = oc; t.exp_d = ed; t.exp_ovf = eo;
        tbl.push_back(t);
    endtask

    // Drive one command for one edge, then check the wrap instance's outputs.
    task automatic apply(input logic v, input logic [2:0] o, input logic [1:0] s,
                         input logic [W-1:0] d, input logic oc, input logic r,
                         input logic [W-1:0] ed, input logic [D-1:0] eo);
        logic want;
        op_valid = v; op = o; sel = s; din = d; ovf_clr = oc; rst = r;
        want = v && !r && (o == RD || o == RDC);
        if (want) exp_q.push_back(ed);
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            last_dout = '0;
        end
        chk("dout_valid", {31'd0, dv0}, {31'd0, want});
        if (want && exp_q.size() > 0) last_dout = exp_q.pop_front();
        chk("dout", {14'd0, dout0}, {14'd0, last_dout});
        chk("ovf", {28'd0, ovf0}, {28'd0, eo});
    endtask

    initial begin
        // Reset state
        apply(0, NOP, 0, 0, 0, 1, 0, 4'h0);
        apply(0, NOP, 0, 0, 0, 1, 0, 4'h0);
        chk("sat_reset_dv", {31'd0, dv1}, 32'd0);
        chk("sat_reset_ovf", {28'd0, ovf1}, 32'd0);

        add(1, LD,  2, 18'd100,   0, 0,         4'h0);
        add(1, ADD, 2, 18'd25,    0, 0,         4'h0);
        add(1, RD,  2, 0,         0, 18'd125,   4'h0);
        add(1, RD,  0, 0,         0, 18'd0,     4'h0);
        add(1, RD,  1, 0,         0, 18'd0,     4'h0);
        add(1, RD,  3, 0,         0, 18'd0,     4'h0);
        add(1, LD,  1, 18'h1FFFF, 0, 0,         4'h0);
        add(1, ADD, 1, 18'd1,     0, 0,         4'h2);
        add(1, RD,  1, 0,         0, 18'h20000, 4'h2);
        add(0, RD,  1, 0,         0, 0,         4'h2);
        add(1, LD,  3, 18'd7,     0, 0,         4'h2);
        add(1, RDC, 3, 0,         0, 18'd7,     4'h2);
        add(1, RD,  3, 0,         0, 18'd0,     4'h2);
        add(1, SUB, 0, 18'd5,     0, 0,         4'h2);
        add(1, RD,  0, 0,         0, 18'h3FFFB, 4'h2);
        add(1, RSV, 0, 18'd99,    0, 0,         4'h2);
        add(1, RD,  0, 0,         0, 18'h3FFFB, 4'h2);
        add(1, LD,  0, 18'h20000, 0, 0,         4'h2);
        add(1, SUB, 0, 18'd1,     0, 0,         4'h3);
        add(1, RD,  0, 0,         0, 18'h1FFFF, 4'h3);
        add(1, CLR, 1, 0,         0, 0,         4'h3);
        add(1, RD,  1, 0,         0, 18'd0,     4'h3);
        add(0, NOP, 0, 0,         1, 0,         4'h0);
        add(1, LD,  0, 18'h1FFFF, 0, 0,         4'h0);
        add(1, ADD, 0, 18'd1,     0, 0,         4'h1);
        add(1, LD,  2, 18'h1FFFF, 0, 0,         4'h1);
        add(1, ADD, 2, 18'd5,     1, 0,         4'h4);
        add(1, RD,  2, 0,         0, 18'h20004, 4'h4);
        add(1, ADD, 2, 18'h3FFFC, 0, 0,         4'h4);
        add(1, RD,  2, 0,         0, 18'h20000, 4'h4);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].v, tbl[i].op, tbl[i].sel, tbl[i].din, tbl[i].oc, 0,
                  tbl[i].exp_d, tbl[i].exp_ovf);
        end

        // Reset discards a concurrent command and clears everything
        apply(0, NOP, 0, 0, 0, 1, 0, 4'h0);
        apply(1, LD,  0, 18'd50, 0, 0, 0, 4'h0);
        apply(1, RD,  0, 0,      0, 1, 0, 4'h0);
        apply(1, ADD, 0, 18'd9,  1, 1, 0, 4'h0);
        apply(1, RD,  0, 0,      0, 0, 18'd0, 4'h0);
        apply(1, LD,  1, 18'd3,  0, 0, 0, 4'h0);
        apply(1, RD,  1, 0,      0, 0, 18'd3, 4'h0);

        // Saturating vs wrapping at both ends of the range
        apply(0, NOP, 0, 0, 0, 1, 0, 4'h0);
        apply(1, LD,  1, 18'h20000, 0, 0, 0, 4'h0);
        apply(1, SUB, 1, 18'd5,     0, 0, 0, 4'h2);
        apply(1, RD,  1, 0,         0, 0, 18'h1FFFB, 4'h2);
        chk("sat_min_dout", {14'd0, dout1}, {14'd0, 18'h20000});
        chk("sat_min_dv", {31'd0, dv1}, 32'd1);
        chk("sat_min_ovf", {28'd0, ovf1}, 32'h2);
        apply(1, LD,  2, 18'h1FFFF, 0, 0, 0, 4'h2);
        apply(1, ADD, 2, 18'd10,    0, 0, 0, 4'h6);
        apply(1, RD,  2, 0,         0, 0, 18'h20009, 4'h6);
        chk("sat_max_dout", {14'd0, dout1}, {14'd0, 18'h1FFFF});
        chk("sat_max_ovf", {28'd0, ovf1}, 32'h6);
        apply(0, NOP, 0, 0, 1, 0, 0, 4'h0);
        chk("sat_ovf_clr", {28'd0, ovf1}, 32'h0);

        // Random load / read-back across channels
        for (int i = 0; i < 16; i++) begin
            logic [1:0]   s;
            logic [W-1:0] d;
            s = 2'($urandom_range(0, 3));
            d = W'($urandom_range(0, (1 << W) - 1));
            apply(1, LD, s, d, 0, 0, 0, 4'h0);
            apply(1, RD, s, 0, 0, 0, d, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
